mem_arbiter: RTL and testbench

Arbitrates the single byte-wide RAM port between the instruction cache and the data cache, and sequences each multi-byte access as a series of byte transfers. Each cache issues one request as a single-cycle pulse; the arbiter queues it in a one-entry slot per requester, runs the transfer, and returns a one-cycle done pulse with the assembled word. It sits between icache/dcache and the top-level RAM/IO pins.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_req_slot.sv | 40 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, IO base, state encoding and request types for mem_arbiter
package mem_arbiter_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h30000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   typedef struct packed {
      logic              ls;
      logic [2:0]        len;
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] dt;
   } dreq_t;

   function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/mem_arbiter_req_slot.sv
// rtl/mem_arbiter_req_slot.sv - one-entry request holding slot; a same-cycle pulse is visible immediately
module mem_arbiter_req_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         set,
   input  logic         take,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         vld,
   output logic [W-1:0] dout
);
   logic         vld_q, vld_d;
   logic [W-1:0] dat_q, dat_d;

   always_comb begin
      vld   = ~flush & (vld_q | set);
      dout  = set ? din : dat_q;
      vld_d = vld_q;
      dat_d = dat_q;
      if (set) begin
         vld_d = 1'b1;
         dat_d = din;
      end
      // A pulse consumed by the dispatch in its own cycle must not linger.
      if (take | flush) vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else if (en) begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter between icache fetches and dcache loads/stores
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              i_done,
   output logic [DATA_W-1:0] i_dt,
   input  logic              d_en,
   input  logic              d_ls,
   input  logic [ADDR_W-1:0] d_pc,
   input  logic [DATA_W-1:0] d_dt,
   input  logic [2:0]        d_len,
   output logic              d_done,
   output logic [DATA_W-1:0] d_dt_o,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, len_q, len_d;
   logic              src_q, src_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] wdat_q, wdat_d, buf_q, buf_d;
   logic              i_done_q, i_done_d, d_done_q, d_done_d;
   logic [DATA_W-1:0] i_dt_q, i_dt_d, d_dt_q, d_dt_d;
   logic              i_vld, d_vld, i_take, d_take, fin, stall, mem_wr_c;
   logic [ADDR_W-1:0] i_req;
   dreq_t             d_req;

   mem_arbiter_req_slot #(.W(ADDR_W)) u_islot (
      .clk(clk), .rst(rst), .en(rdy), .set(i_en & rdy), .take(i_take), .flush(clr),
      .din(i_pc), .vld(i_vld), .dout(i_req)
   );

   mem_arbiter_req_slot #(.W($bits(dreq_t))) u_dslot (
      .clk(clk), .rst(rst), .en(rdy), .set(d_en & rdy), .take(d_take), .flush(1'b0),
      .din({d_ls, d_len, d_pc, d_dt}), .vld(d_vld), .dout(d_req)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      src_d    = src_q;
      base_d   = base_q;
      wdat_d   = wdat_q;
      buf_d    = buf_q;
      i_dt_d   = i_dt_q;
      d_dt_d   = d_dt_q;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
      i_take   = 1'b0;
      d_take   = 1'b0;
      fin      = 1'b0;
      mem_a    = '0;
      mem_wr_c = 1'b0;
      mem_dout = '0;
      stall    = (base_q >= IO_BASE) && io_buffer_full;
      case (state_q)
         ST_READ: begin
            if (cnt_q < len_q) mem_a = base_q + ADDR_W'(cnt_q);
            // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
            if (cnt_q != 3'd0) buf_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
            cnt_d = cnt_q + 3'd1;
            if (!src_q && clr) begin
               fin = 1'b1;
            end else if (cnt_q == len_q) begin
               fin = 1'b1;
               if (src_q) begin
                  d_done_d = 1'b1;
                  d_dt_d   = buf_d;
               end else begin
                  i_done_d = 1'b1;
                  i_dt_d   = buf_d;
               end
            end
         end
         ST_WRITE: begin
            if (!stall) begin
               mem_wr_c = 1'b1;
               mem_a    = base_q + ADDR_W'(cnt_q);
               mem_dout = byte_sel(wdat_q, cnt_q[1:0]);
               cnt_d    = cnt_q + 3'd1;
               if (cnt_q == len_q - 3'd1) begin
                  fin      = 1'b1;
                  d_done_d = 1'b1;
               end
            end
         end
         default: fin = 1'b1;
      endcase
      // Dispatch at the completion edge; dcache has priority, no preemption.
      if (fin) begin
         state_d = ST_IDLE;
         if (d_vld) begin
            d_take  = 1'b1;
            state_d = d_req.ls ? ST_WRITE : ST_READ;
            src_d   = 1'b1;
            base_d  = d_req.pc;
            len_d   = d_req.len;
            wdat_d  = d_req.dt;
            cnt_d   = 3'd0;
            buf_d   = '0;
         end else if (i_vld) begin
            i_take  = 1'b1;
            state_d = ST_READ;
            src_d   = 1'b0;
            base_d  = i_req;
            len_d   = 3'd4;
            cnt_d   = 3'd0;
            buf_d   = '0;
         end
      end
   end

   assign mem_wr = mem_wr_c & rdy;
   assign i_done = i_done_q;
   assign d_done = d_done_q;
   assign i_dt   = i_dt_q;
   assign d_dt_o = d_dt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         src_q    <= 1'b0;
         base_q   <= '0;
         wdat_q   <= '0;
         buf_q    <= '0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         i_dt_q   <= '0;
         d_dt_q   <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         src_q    <= src_d;
         base_q   <= base_d;
         wdat_q   <= wdat_d;
         buf_q    <= buf_d;
         i_done_q <= i_done_d;
         d_done_q <= d_done_d;
         i_dt_q   <= i_dt_d;
         d_dt_q   <= d_dt_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed vectors
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clr = 1'b0;
   logic        i_en = 1'b0, d_en = 1'b0, d_ls = 1'b0, io_buffer_full = 1'b0;
   logic [31:0] i_pc = '0, d_pc = '0, d_dt = '0;
   logic [2:0]  d_len = '0;
   logic [7:0]  mem_din = '0;
   logic        i_done, d_done, mem_wr;
   logic [31:0] i_dt, d_dt_o, mem_a;
   logic [7:0]  mem_dout;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .i_en(i_en), .i_pc(i_pc), .i_done(i_done), .i_dt(i_dt),
      .d_en(d_en), .d_ls(d_ls), .d_pc(d_pc), .d_dt(d_dt), .d_len(d_len),
      .d_done(d_done), .d_dt_o(d_dt_o),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   typedef struct {
      int          cyc;
      bit          is_d;
      bit          chk;
      logic [31:0] data;
   } done_t;
   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic        wr;
      logic [7:0]  dout;
   } bus_t;
   done_t done_q[$];
   bus_t  bus_q[$];

   bit [7:0] ram [int];

   // RAM model: registered read, frozen together with the core when rdy is low.
   always @(posedge clk) begin
      if (rst) begin
         mem_din <= '0;
      end else if (rdy) begin
         mem_din <= ram[int'(mem_a)];
         if (mem_wr) ram[int'(mem_a)] = mem_dout;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      done_t e;
      if (!rst) begin
         while (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
            chk("mem_a", mem_a, bus_q[0].a);
            chk("mem_wr", 32'(mem_wr), 32'(bus_q[0].wr));
            chk("mem_dout", 32'(mem_dout), 32'(bus_q[0].dout));
            void'(bus_q.pop_front());
         end
         if (i_done && d_done) begin
            chk("done_overlap", 32'(i_done & d_done), 32'd0);
         end else if (i_done || d_done) begin
            if (done_q.size() == 0) begin
               chk("spurious_done", 32'({i_done, d_done}), 32'd0);
            end else begin
               e = done_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
               chk("done_port", 32'(d_done), 32'(e.is_d));
               if (e.chk) chk("done_data", d_done ? d_dt_o : i_dt, e.data);
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic pb(input int c, input logic [31:0] a, input logic wr, input logic [7:0] d);
      bus_t b;
      b.cyc = c; b.a = a; b.wr = wr; b.dout = d;
      bus_q.push_back(b);
   endtask

   task automatic pd(input int c, input bit is_d, input bit ck, input logic [31:0] data);
      done_t e;
      e.cyc = c; e.is_d = is_d; e.chk = ck; e.data = data;
      done_q.push_back(e);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((done_q.size() > 0 || bus_q.size() > 0) && n < max) begin
         next();
         n++;
      end
      if (done_q.size() > 0 || bus_q.size() > 0) begin
         chk("timeout_pending", 32'(done_q.size() + bus_q.size()), 32'd0);
         done_q.delete();
         bus_q.delete();
      end
      repeat (3) next();
   endtask

   task automatic dreq(input logic ls, input logic [31:0] pc, input logic [31:0] dt, input logic [2:0] len);
      d_en = 1'b1; d_ls = ls; d_pc = pc; d_dt = dt; d_len = len;
   endtask

   int t0;

   initial begin
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      ram[32'h300] = 8'h5A;
      ram[32'h400] = 8'h01; ram[32'h401] = 8'h02; ram[32'h402] = 8'h03; ram[32'h403] = 8'h04;
      ram[32'h500] = 8'hAA; ram[32'h501] = 8'hBB; ram[32'h502] = 8'hCC; ram[32'h503] = 8'hDD;
      ram[32'h600] = 8'h10; ram[32'h601] = 8'h20; ram[32'h602] = 8'h30; ram[32'h603] = 8'h40;

      repeat (3) next();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_dout", 32'(mem_dout), 32'd0);
      chk("rst_done", 32'({i_done, d_done}), 32'd0);
      chk("rst_i_dt", i_dt, 32'd0);
      chk("rst_d_dt_o", d_dt_o, 32'd0);

      // Load len 4 at 0x100.
      next(); t0 = cyc; dreq(1'b0, 32'h100, 32'h0, 3'd4);
      for (int k = 0; k < 4; k++) pb(t0 + 1 + k, 32'h100 + 32'(k), 1'b0, 8'h00);
      pd(t0 + 6, 1'b1, 1'b1, 32'h44332211);
      next(); d_en = 1'b0;
      drain(30);

      // Store len 2 at 0x200.
      next(); t0 = cyc; dreq(1'b1, 32'h200, 32'h0000ABCD, 3'd2);
      pb(t0 + 1, 32'h200, 1'b1, 8'hCD);
      pb(t0 + 2, 32'h201, 1'b1, 8'hAB);
      pb(t0 + 3, 32'h0, 1'b0, 8'h00);
      pd(t0 + 3, 1'b1, 1'b0, 32'h0);
      next(); d_en = 1'b0;
      drain(30);
      chk("ram_200", 32'(ram[32'h200]), 32'hCD);
      chk("ram_201", 32'(ram[32'h201]), 32'hAB);

      // Simultaneous fetch and len 1 load: dcache first, fetch follows with no bubble.
      next(); t0 = cyc; dreq(1'b0, 32'h300, 32'h0, 3'd1); i_en = 1'b1; i_pc = 32'h400;
      pb(t0 + 1, 32'h300, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) pb(t0 + 3 + k, 32'h400 + 32'(k), 1'b0, 8'h00);
      pd(t0 + 3, 1'b1, 1'b1, 32'h0000005A);
      pd(t0 + 8, 1'b0, 1'b1, 32'h04030201);
      next(); d_en = 1'b0; i_en = 1'b0;
      drain(30);

      // IO store stalled by a full write buffer for three cycles.
      next(); t0 = cyc; dreq(1'b1, 32'h30000, 32'h00000077, 3'd1);
      for (int k = 1; k <= 3; k++) pb(t0 + k, 32'h0, 1'b0, 8'h00);
      pb(t0 + 4, 32'h30000, 1'b1, 8'h77);
      pb(t0 + 5, 32'h0, 1'b0, 8'h00);
      pd(t0 + 5, 1'b1, 1'b0, 32'h0);
      next(); d_en = 1'b0; io_buffer_full = 1'b1;
      next();
      next();
      next(); io_buffer_full = 1'b0;
      drain(30);
      chk("ram_io", 32'(ram[32'h30000]), 32'h77);

      // Flush in cycle 2 of a fetch aborts it silently.
      next(); t0 = cyc; i_en = 1'b1; i_pc = 32'h400;
      pb(t0 + 1, 32'h400, 1'b0, 8'h00);
      pb(t0 + 2, 32'h401, 1'b0, 8'h00);
      pb(t0 + 3, 32'h0, 1'b0, 8'h00);
      pb(t0 + 4, 32'h0, 1'b0, 8'h00);
      next(); i_en = 1'b0;
      next(); clr = 1'b1;
      next(); clr = 1'b0;
      drain(30);
      repeat (8) next();
      chk("i_dt_hold", i_dt, 32'h04030201);
      next(); t0 = cyc; i_en = 1'b1; i_pc = 32'h500;
      pb(t0 + 1, 32'h500, 1'b0, 8'h00);
      pd(t0 + 6, 1'b0, 1'b1, 32'hDDCCBBAA);
      next(); i_en = 1'b0;
      drain(30);

      // rdy low in cycles 2-3 of a len 4 load.
      next(); t0 = cyc; dreq(1'b0, 32'h600, 32'h0, 3'd4);
      pb(t0 + 1, 32'h600, 1'b0, 8'h00);
      pb(t0 + 2, 32'h601, 1'b0, 8'h00);
      pb(t0 + 3, 32'h601, 1'b0, 8'h00);
      pb(t0 + 4, 32'h601, 1'b0, 8'h00);
      pb(t0 + 5, 32'h602, 1'b0, 8'h00);
      pb(t0 + 6, 32'h603, 1'b0, 8'h00);
      pd(t0 + 8, 1'b1, 1'b1, 32'h40302010);
      next(); d_en = 1'b0;
      next(); rdy = 1'b0;
      next();
      next(); rdy = 1'b1;
      drain(30);

      // Len 2 load is zero-extended.
      next(); t0 = cyc; dreq(1'b0, 32'h102, 32'h0, 3'd2);
      pb(t0 + 1, 32'h102, 1'b0, 8'h00);
      pb(t0 + 2, 32'h103, 1'b0, 8'h00);
      pb(t0 + 4, 32'h0, 1'b0, 8'h00);
      pd(t0 + 4, 1'b1, 1'b1, 32'h00004433);
      next(); d_en = 1'b0;
      drain(30);

      // Len 4 store with a fetch waiting behind it, then read the word back.
      next(); t0 = cyc; dreq(1'b1, 32'h700, 32'hCAFEF00D, 3'd4); i_en = 1'b1; i_pc = 32'h100;
      pb(t0 + 1, 32'h700, 1'b1, 8'h0D);
      pb(t0 + 2, 32'h701, 1'b1, 8'hF0);
      pb(t0 + 3, 32'h702, 1'b1, 8'hFE);
      pb(t0 + 4, 32'h703, 1'b1, 8'hCA);
      for (int k = 0; k < 4; k++) pb(t0 + 5 + k, 32'h100 + 32'(k), 1'b0, 8'h00);
      pd(t0 + 5, 1'b1, 1'b0, 32'h0);
      pd(t0 + 10, 1'b0, 1'b1, 32'h44332211);
      next(); d_en = 1'b0; i_en = 1'b0;
      drain(40);
      next(); t0 = cyc; dreq(1'b0, 32'h700, 32'h0, 3'd4);
      pd(t0 + 6, 1'b1, 1'b1, 32'hCAFEF00D);
      next(); d_en = 1'b0;
      drain(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
